// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported 2048x32 data memory between the
// pipeline MEM stage (CPU, priority) and a debug/loader port (DBG, one-word
// slots granted when the CPU is idle or after a bounded starvation wait).
// Optional build macro DMEM_DBG_WPROT_EN: blocks DBG writes below WPROT_TOP
// and reports them on dbg_err; without it dbg_err is held at 0.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned WPROT_TOP    = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [10:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [10:0] mem_address,
  output logic [31:0] mem_in_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_out_data
);

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_DBG_ACC = 2'd1,
    S_DBG_ACK = 2'd2
  } state_t;

`ifdef DMEM_DBG_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  state_t      state;
  logic [7:0]  starve_cnt;
  logic        dbg_we_q;
  logic [10:0] dbg_addr_q;
  logic [31:0] dbg_wdata_q;
  logic        dbg_blocked;
  logic        grant;
  logic        in_acc;

  // Slot decision and write-protection qualification of the latched request
  always_comb begin
    in_acc      = (state == S_DBG_ACC);
    dbg_blocked = WPROT_ON && dbg_we_q && (32'(dbg_addr_q) < WPROT_TOP);
    grant       = (state == S_CPU) && dbg_req &&
                  (!cpu_req || (starve_cnt == 8'(STARVE_LIMIT - 1)));
  end

  // Arbitration FSM, starvation counter and registered DBG responses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CPU;
      starve_cnt  <= '0;
      dbg_rdata   <= '0;
      dbg_ack     <= 1'b0;
      dbg_err     <= 1'b0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
    end else begin
      dbg_ack <= 1'b0;
      dbg_err <= 1'b0;
      case (state)
        S_CPU: begin
          if (grant) begin
            state       <= S_DBG_ACC;
            starve_cnt  <= '0;
            dbg_we_q    <= dbg_we;
            dbg_addr_q  <= dbg_addr;
            dbg_wdata_q <= dbg_wdata;
          end else if (dbg_req && cpu_req && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        S_DBG_ACC: begin
          // mem_out_data already holds the negedge read of the latched address
          if (!dbg_we_q) dbg_rdata <= mem_out_data;
          dbg_ack <= 1'b1;
          dbg_err <= dbg_blocked;
          state   <= S_DBG_ACK;
        end
        S_DBG_ACK: state <= S_CPU;
        default:   state <= S_CPU;
      endcase
    end
  end

  // Memory port mux; strobes are gated by reset so an aborted slot never writes
  always_comb begin
    cpu_rdata = mem_out_data;
    cpu_stall = in_acc && cpu_req;
    if (in_acc) begin
      mem_address  = dbg_addr_q;
      mem_in_data  = dbg_wdata_q;
      mem_MemWrite = reset_n && dbg_we_q && !dbg_blocked;
      mem_MemRead  = reset_n && !dbg_we_q;
    end else begin
      mem_address  = cpu_addr;
      mem_in_data  = cpu_wdata;
      mem_MemWrite = reset_n && cpu_req && cpu_we;
      mem_MemRead  = reset_n && cpu_req && !cpu_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural data memory, a
// schedule-based reference model compared every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_dmem_arbiter;

  localparam int unsigned LIMIT = 8;
  localparam int unsigned PTOP  = 256;
`ifdef DMEM_DBG_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [10:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic [10:0] mem_address;
  logic [31:0] mem_in_data;
  logic        mem_MemWrite, mem_MemRead;
  logic [31:0] mem_out_data;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .WPROT_TOP(PTOP)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .dbg_err(dbg_err), .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_out_data(mem_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical data memory: write at posedge, read at negedge
  logic [31:0] pmem [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) pmem[i] = '0;
    mem_out_data = '0;
  end
  always @(posedge clock) if (mem_MemWrite) pmem[mem_address] <= mem_in_data;
  always @(negedge clock) mem_out_data <= pmem[mem_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: golden memory plus a schedule of the DBG slot cycles
  logic [31:0] gmem [0:2047];
  int          cyc, acc_c, ack_c;
  int unsigned waitc;
  logic        lat_we, lat_blk;
  logic [10:0] lat_addr;
  logic [31:0] lat_wdata, exp_rdata;
  initial begin
    for (int i = 0; i < 2048; i++) gmem[i] = '0;
    cyc = 0; acc_c = -10; ack_c = -10; waitc = 0; exp_rdata = '0;
    lat_we = 1'b0; lat_blk = 1'b0; lat_addr = '0; lat_wdata = '0;
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      cyc = 0; acc_c = -10; ack_c = -10; waitc = 0; exp_rdata = '0;
    end else begin
      if (cyc == acc_c) begin
        if (lat_we) begin
          if (!lat_blk) gmem[lat_addr] = lat_wdata;
        end else begin
          exp_rdata = gmem[lat_addr];
        end
      end else if (cpu_req && cpu_we) begin
        gmem[cpu_addr] = cpu_wdata;
      end
      if (cyc > ack_c) begin
        if (dbg_req && (!cpu_req || waitc == LIMIT - 1)) begin
          acc_c = cyc + 1; ack_c = cyc + 2; waitc = 0;
          lat_we = dbg_we; lat_addr = dbg_addr; lat_wdata = dbg_wdata;
          lat_blk = PROT && dbg_we && (int'(dbg_addr) < int'(PTOP));
        end else if (dbg_req && cpu_req && waitc < 255) begin
          waitc++;
        end
      end
      cyc++;
    end
  end

  // Compare process: outputs checked against the model every cycle
  logic m_acc, m_ack;
  always @(negedge clock) begin
    #1;
    if (started) begin
      if (!reset_n) begin
        chk("rst_memwrite", 32'(mem_MemWrite), 32'd0);
        chk("rst_memread",  32'(mem_MemRead),  32'd0);
        chk("rst_ack",      32'(dbg_ack),      32'd0);
        chk("rst_err",      32'(dbg_err),      32'd0);
        chk("rst_rdata",    dbg_rdata,         32'd0);
        chk("rst_stall",    32'(cpu_stall),    32'd0);
      end else begin
        m_acc = (cyc == acc_c);
        m_ack = (cyc == ack_c);
        chk("stall",   32'(cpu_stall), 32'(m_acc && cpu_req));
        chk("addr",    32'(mem_address), 32'(m_acc ? lat_addr : cpu_addr));
        chk("wdata",   mem_in_data, m_acc ? lat_wdata : cpu_wdata);
        chk("memwrite", 32'(mem_MemWrite),
            32'(m_acc ? (lat_we && !lat_blk) : (cpu_req && cpu_we)));
        chk("memread", 32'(mem_MemRead), 32'(m_acc ? !lat_we : (cpu_req && !cpu_we)));
        chk("ack",     32'(dbg_ack), 32'(m_ack));
        chk("err",     32'(dbg_err), 32'(m_ack && lat_blk));
        chk("dbg_rdata", dbg_rdata, exp_rdata);
        if (!m_acc && cpu_req && !cpu_we) chk("cpu_rdata", cpu_rdata, gmem[cpu_addr]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic dbg_txn(input string nm, input logic we, input logic [10:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] rd, output logic er);
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!dbg_ack && lat < 40);
    chk({nm, "_ack_seen"}, 32'(dbg_ack), 32'd1);
    rd = dbg_rdata;
    er = dbg_err;
    dbg_req = 1'b0;
  endtask

  function automatic logic [10:0] raddr();
    if ($urandom_range(0, 3) == 0) return 11'(250 + $urandom_range(0, 60));
    return 11'($urandom_range(0, 31));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int lat, stall_cnt, stall_n, ack_n, k;
    int acks [3];
    logic [31:0] rd;
    logic er, ack_seen, was_stalled, ack_now;

    reset_n = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    #2 reset_n = 1'b0;
    started = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset in the middle of a DBG write slot
    dbg_we = 1; dbg_addr = 11'd7; dbg_wdata = 32'hCAFEF00D; dbg_req = 1;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'd3;
    #1;
    chk("t1_in_slot", 32'(cpu_stall), 32'd1);
    reset_n = 0; dbg_req = 0; cpu_req = 0;
    #1;
    chk("t1_write_gated", 32'(mem_MemWrite), 32'd0);
    ack_seen = 0;
    repeat (3) begin tick(); ack_seen |= dbg_ack; end
    reset_n = 1;
    repeat (4) begin tick(); ack_seen |= dbg_ack; end
    chk("t1_no_ack", 32'(ack_seen), 32'd0);
    chk("t1_mem_untouched", pmem[7], 32'd0);

    // 2: CPU idle, write then read back
    dbg_txn("t2_wr", 1'b1, 11'd5, 32'hDEADBEEF, lat, rd, er);
    chk("t2_wr_latency", lat, 2);
    tick();
    dbg_txn("t2_rd", 1'b0, 11'd5, 32'h0, lat, rd, er);
    chk("t2_rd_latency", lat, 2);
    chk("t2_rd_data", rd, 32'hDEADBEEF);
    tick();

    // 3+4: starvation with a CPU write just before the forced slot
    dbg_we = 0; dbg_addr = 11'd20; dbg_wdata = '0; dbg_req = 1;
    stall_cnt = 0; stall_n = -1; ack_n = -1; rd = '0;
    for (int n = 0; n < 14; n++) begin
      cpu_req   = (n < 10);
      cpu_we    = (n >= 7);
      cpu_addr  = (n == 7) ? 11'd20 : (n >= 8) ? 11'd21 : 11'(n);
      cpu_wdata = (n == 7) ? 32'h11 : 32'h22;
      #1;
      if (cpu_stall) begin stall_cnt++; stall_n = n; end
      if (dbg_ack && ack_n < 0) begin ack_n = n; rd = dbg_rdata; dbg_req = 0; end
      tick();
    end
    cpu_req = 0;
    tick();
    chk("t3_stall_cycle", stall_n, 8);
    chk("t3_stall_count", stall_cnt, 1);
    chk("t3_ack_cycle", ack_n, 9);
    chk("t4_rdata", rd, 32'h11);
    chk("t4_cpu_write20", pmem[20], 32'h11);
    chk("t4_reissued_write21", pmem[21], 32'h22);

    // 5: write protection
    dbg_txn("t5_lo", 1'b1, 11'd10, 32'h5555AAAA, lat, rd, er);
    tick();
    chk("t5_lo_err", 32'(er), 32'(PROT));
    chk("t5_lo_mem", pmem[10], PROT ? 32'd0 : 32'h5555AAAA);
    dbg_txn("t5_hi", 1'b1, 11'd300, 32'h00003030, lat, rd, er);
    tick();
    chk("t5_hi_err", 32'(er), 32'd0);
    chk("t5_hi_mem", pmem[300], 32'h00003030);
    dbg_txn("t5_rd", 1'b0, 11'd300, 32'h0, lat, rd, er);
    tick();
    chk("t5_rd_data", rd, 32'h00003030);

    // 6: held dbg_req -> one transaction every 3 cycles
    dbg_we = 1; dbg_addr = 11'd40; dbg_wdata = 32'h100; dbg_req = 1;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (dbg_ack && k < 3) begin
        acks[k] = n; k++;
        if (k == 3) dbg_req = 0;
        else begin dbg_addr = 11'(40 + k); dbg_wdata = 32'(256 + k); end
      end
    end
    chk("t6_ack_count", k, 3);
    chk("t6_first_ack", acks[0], 2);
    chk("t6_gap1", acks[1] - acks[0], 3);
    chk("t6_gap2", acks[2] - acks[1], 3);
    chk("t6_mem42", pmem[42], 32'h102);

    // Randomized traffic against the model
    for (int t = 0; t < 4000; t++) begin
      #3;
      was_stalled = cpu_stall;
      ack_now = dbg_ack;
      tick();
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 0; dbg_req = 0; cpu_req = 0;
        repeat (2) tick();
        reset_n = 1;
      end else begin
        if (!was_stalled) begin
          cpu_req = ($urandom_range(0, 9) < 6);
          cpu_we = $urandom_range(0, 1) == 1;
          cpu_addr = raddr();
          cpu_wdata = $urandom;
        end
        if (dbg_req && ack_now) begin
          dbg_req = $urandom_range(0, 1) == 1;
          dbg_we = $urandom_range(0, 1) == 1;
          dbg_addr = raddr();
          dbg_wdata = $urandom;
        end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
          dbg_req = 1;
          dbg_we = $urandom_range(0, 1) == 1;
          dbg_addr = raddr();
          dbg_wdata = $urandom;
        end
      end
    end
    cpu_req = 0; dbg_req = 0;
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
